// File: rtl/count_sweep_pkg.sv
// Shared types for the count sweep controller: FSM state encoding, the latched
// command bundle and the direction helper.
package count_sweep_pkg;

  // Default widths. The latched command struct is sized from these, so the top-level
  // WIDTH/DIVW parameters must keep the same values.
  localparam int unsigned SweepWidth = 8;
  localparam int unsigned SweepDivw  = 4;

  localparam logic [1:0] EncIdle = 2'd0;
  localparam logic [1:0] EncLoad = 2'd1;
  localparam logic [1:0] EncRun  = 2'd2;
  localparam logic [1:0] EncDone = 2'd3;

  typedef enum logic [1:0] {
    StIdle = EncIdle,
    StLoad = EncLoad,
    StRun  = EncRun,
    StDone = EncDone
  } sweep_state_e;

  typedef struct packed {
    logic [SweepWidth-1:0] start_val;
    logic [SweepWidth-1:0] end_val;
    logic [SweepDivw-1:0]  div;
  } sweep_cmd_t;

  // Count up when the end lies above the start; equal values never step.
  function automatic logic sweep_dir(input logic [SweepWidth-1:0] start_val,
                                     input logic [SweepWidth-1:0] end_val);
    return end_val > start_val;
  endfunction

endpackage

// File: rtl/sweep_div_tick.sv
// Step-rate divider: tick is high once every div+1 cycles while clear is low.
module sweep_div_tick #(
  parameter int unsigned DIVW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic [DIVW-1:0] div,
  output logic            tick
);

  logic [DIVW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == div);

  // Restart on clear or after each tick, otherwise keep counting.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  // Divider count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/count_sweep_ctrl.sv
// Sweep sequencer for a loadable up/down counter that has no enable: every
// non-step cycle reloads the counter's own value to freeze it.
// Optional feature macro: SWEEP_PINGPONG_EN (sweep out to end and back to start).
module count_sweep_ctrl
  import count_sweep_pkg::*;
#(
  parameter int unsigned WIDTH = SweepWidth,
  parameter int unsigned DIVW  = SweepDivw
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_end,
  input  logic [DIVW-1:0]  cmd_div,
  input  logic             abort,
  input  logic [WIDTH-1:0] ctr_count,
  output logic             ctr_load,
  output logic             ctr_m,
  output logic [WIDTH-1:0] ctr_data,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  sweep_state_e state_q, state_d;
  sweep_cmd_t   cmd_q, cmd_d;
  logic         dir_q, dir_d;
  logic         aborted_q, aborted_d;
  logic         div_clear;
  logic         tick;
  logic         at_end;

`ifdef SWEEP_PINGPONG_EN
  // Set once the first leg has turned around.
  logic         leg_q, leg_d;
`endif

  sweep_div_tick #(
    .DIVW (DIVW)
  ) u_div_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (div_clear),
    .div   (cmd_q.div),
    .tick  (tick)
  );

  assign at_end = (ctr_count == cmd_q.end_val);

  // Next-state and counter drive; default is to hold the counter by reloading it.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    dir_d     = dir_q;
    aborted_d = aborted_q;
`ifdef SWEEP_PINGPONG_EN
    leg_d     = leg_q;
`endif
    div_clear = 1'b1;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    aborted   = 1'b0;
    ctr_load  = 1'b1;
    ctr_m     = 1'b0;
    ctr_data  = ctr_count;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cmd_d.start_val = cmd_start;
          cmd_d.end_val   = cmd_end;
          cmd_d.div       = cmd_div;
          dir_d           = sweep_dir(cmd_start, cmd_end);
          aborted_d       = 1'b0;
`ifdef SWEEP_PINGPONG_EN
          leg_d           = 1'b0;
`endif
          state_d         = StLoad;
        end
      end

      StLoad: begin
        busy = 1'b1;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = StDone;
        end else begin
          ctr_data = cmd_q.start_val;
          state_d  = StRun;
        end
      end

      StRun: begin
        busy      = 1'b1;
        div_clear = 1'b0;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = StDone;
        end else if (at_end) begin
`ifdef SWEEP_PINGPONG_EN
          // Degenerate start==end completes without a return leg.
          if (!leg_q && (cmd_q.start_val != cmd_q.end_val)) begin
            cmd_d.start_val = cmd_q.end_val;
            cmd_d.end_val   = cmd_q.start_val;
            dir_d           = ~dir_q;
            leg_d           = 1'b1;
            div_clear       = 1'b1;
          end else begin
            state_d = StDone;
          end
`else
          state_d = StDone;
`endif
        end else if (tick) begin
          ctr_load = 1'b0;
          ctr_m    = dir_q;
        end
      end

      StDone: begin
        done      = 1'b1;
        aborted   = aborted_q;
        aborted_d = 1'b0;
        state_d   = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // State and latched command registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cmd_q     <= '0;
      dir_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      dir_q     <= dir_d;
      aborted_q <= aborted_d;
    end
  end

`ifdef SWEEP_PINGPONG_EN
  // Leg tracking register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leg_q <= 1'b0;
    end else begin
      leg_q <= leg_d;
    end
  end
`endif

endmodule

// File: tb/tb_count_sweep_ctrl.sv
// Directed bench for count_sweep_ctrl with a behavioural model of the counter.
module tb_count_sweep_ctrl;

`ifdef SWEEP_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_start = '0;
  logic [7:0] cmd_end = '0;
  logic [3:0] cmd_div = '0;
  logic       abort = 1'b0;
  logic [7:0] ctr_count;
  logic       ctr_load;
  logic       ctr_m;
  logic [7:0] ctr_data;
  logic       busy;
  logic       done;
  logic       aborted;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  count_sweep_ctrl #(
    .WIDTH (8),
    .DIVW  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_start (cmd_start),
    .cmd_end   (cmd_end),
    .cmd_div   (cmd_div),
    .abort     (abort),
    .ctr_count (ctr_count),
    .ctr_load  (ctr_load),
    .ctr_m     (ctr_m),
    .ctr_data  (ctr_data),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  // Counter model: load wins, otherwise step up (m=1) or down (m=0).
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (ctr_load) cnt <= ctr_data;
    else if (ctr_m) cnt <= cnt + 8'd1;
    else cnt <= cnt - 8'd1;
  end
  assign ctr_count = cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input string tag, input logic [7:0] s, input logic [7:0] e,
                      input logic [3:0] d);
    @(negedge clk);
    cmd_start = s;
    cmd_end   = e;
    cmd_div   = d;
    cmd_valid = 1'b1;
    #1;
    chk({tag, "/ready"}, cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Cycle 1 after accept is LOAD; returns the cycle index where done is seen.
  task automatic run_to_done(input string tag, input logic [7:0] s, input int abort_k,
                             output int lat, output int ups, output int downs);
    lat = 0;
    ups = 0;
    downs = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      abort = (k == abort_k);
      #1;
      if (k == 1) begin
        chk({tag, "/load_data"}, ctr_data, s);
        chk({tag, "/load_busy"}, busy, 1);
        chk({tag, "/load_ready"}, cmd_ready, 0);
      end
      if (!ctr_load) begin
        if (ctr_m) ups++;
        else downs++;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    abort = 1'b0;
  endtask

  task automatic sweep(input string tag, input logic [7:0] s, input int abort_k,
                       input int e_lat, input int e_up, input int e_dn,
                       input logic [7:0] e_fin, input logic e_ab);
    int lat, ups, downs;
    run_to_done(tag, s, abort_k, lat, ups, downs);
    chk({tag, "/latency"}, lat, e_lat);
    chk({tag, "/up_steps"}, ups, e_up);
    chk({tag, "/down_steps"}, downs, e_dn);
    chk({tag, "/final_count"}, ctr_count, e_fin);
    chk({tag, "/aborted"}, aborted, e_ab);
    chk({tag, "/done_busy"}, busy, 0);
  endtask

  initial begin
    logic seen_done;

    // Reset state with the counter model also cleared.
    #2;
    chk("rst/ready", cmd_ready, 1);
    chk("rst/busy", busy, 0);
    chk("rst/done", done, 0);
    chk("rst/aborted", aborted, 0);
    chk("rst/load", ctr_load, 1);
    chk("rst/m", ctr_m, 0);
    chk("rst/data", ctr_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Up sweep, step every cycle.
    send("up", 8'd3, 8'd6, 4'd0);
    sweep("up", 8'd3, 0, PP ? 10 : 6, 3, PP ? 3 : 0, PP ? 8'd3 : 8'd6, 1'b0);
    @(negedge clk);
    #1;
    chk("up/idle_ready", cmd_ready, 1);
    chk("up/idle_done", done, 0);
    chk("up/hold", ctr_count, PP ? 8'd3 : 8'd6);

    // Down sweep, step every third cycle.
    send("down", 8'd10, 8'd7, 4'd2);
    sweep("down", 8'd10, 0, PP ? 22 : 12, PP ? 3 : 0, 3, PP ? 8'd10 : 8'd7, 1'b0);

    // start == end: no steps, done three cycles after accept.
    send("equal", 8'h55, 8'h55, 4'd5);
    sweep("equal", 8'h55, 0, 3, 0, 0, 8'h55, 1'b0);

    // Abort at RUN cycle 5 (cycle 7 after accept) holds the count at 5.
    send("abort", 8'd0, 8'd200, 4'd0);
    sweep("abort", 8'd0, 7, 8, 5, 0, 8'd5, 1'b1);
    @(negedge clk);
    #1;
    chk("abort/idle_ready", cmd_ready, 1);
    chk("abort/idle_count", ctr_count, 8'd5);

    // Abort while idle is ignored.
    @(negedge clk);
    abort = 1'b1;
    #1;
    chk("idle_abort/busy", busy, 0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("idle_abort/done", done, 0);
    chk("idle_abort/ready", cmd_ready, 1);

    // Second command held while busy is accepted only after done.
    send("cmdA", 8'd20, 8'd23, 4'd0);
    cmd_start = 8'd40;
    cmd_end   = 8'd38;
    cmd_div   = 4'd0;
    cmd_valid = 1'b1;
    sweep("cmdA", 8'd20, 0, PP ? 10 : 6, 3, PP ? 3 : 0, PP ? 8'd20 : 8'd23, 1'b0);
    @(negedge clk);
    #1;
    chk("cmdB/ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    sweep("cmdB", 8'd40, 0, PP ? 8 : 5, PP ? 2 : 0, 2, PP ? 8'd40 : 8'd38, 1'b0);

    // Reset mid-RUN returns to reset values without a done pulse.
    send("rst_mid", 8'd0, 8'd50, 4'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid/busy", busy, 0);
    chk("rst_mid/ready", cmd_ready, 1);
    chk("rst_mid/load", ctr_load, 1);
    chk("rst_mid/m", ctr_m, 0);
    chk("rst_mid/data", ctr_data, 8'h00);
    seen_done = done;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      seen_done = seen_done | done;
    end
    chk("rst_mid/no_done", seen_done, 0);
    chk("rst_mid/idle", busy, 0);

    // Recovery sweep with a divide-by-two step rate.
    send("recover", 8'd7, 8'd9, 4'd1);
    sweep("recover", 8'd7, 0, PP ? 12 : 7, 2, PP ? 2 : 0, PP ? 8'd7 : 8'd9, 1'b0);

    // Short sweep: 2,3,4 (and back to 2 in ping-pong builds).
    send("short", 8'd2, 8'd4, 4'd0);
    sweep("short", 8'd2, 0, PP ? 8 : 5, 2, PP ? 2 : 0, PP ? 8'd2 : 8'd4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
